// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-file constants and default latency/timeout values.
package hazard_ctrl_pkg;

    typedef enum logic {
        HZ_RUN  = 1'b0,
        HZ_BUSY = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int DEFAULT_MULDIV_LAT  = 4;
    localparam int DEFAULT_MEM_TIMEOUT = 255;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset/clear; used for the
// data-memory wait monitor and the stall performance counter.
module hz_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble generator for the 5-stage core: resolves memory wait, mul/div
// occupancy, EX redirect and load-use, plus a timeout flag and stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT  = DEFAULT_MULDIV_LAT,
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        muldiv_start,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        pc_bubble,
    output logic        if_id_stall,
    output logic        if_id_bubble,
    output logic        id_ex_stall,
    output logic        id_ex_bubble,
    output logic        ex_mem_stall,
    output logic        ex_mem_bubble,
    output logic        mem_wb_stall,
    output logic        mem_wb_bubble,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output state_t      dbg_state,
    output logic [$clog2((MULDIV_LAT > 1) ? MULDIV_LAT : 2)-1:0] dbg_cnt
);

    localparam int CNT_W = $clog2((MULDIV_LAT > 1) ? MULDIV_LAT : 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);
    localparam bit MD_EN = (MULDIV_LAT > 1);
    localparam int MW_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [MW_W-1:0] TIMEOUT_V = MW_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             mw;
    logic             lu;
    logic             md;
    logic [MW_W-1:0]  memwait_cnt;

    assign mw = dmem_req & ~dmem_ready;
    assign lu = ex_mem_read && (ex_rd != REG_X0) &&
                (((ex_rd == id_rs1) && id_uses_rs1) || ((ex_rd == id_rs2) && id_uses_rs2));
    assign md = ((state == HZ_RUN) && muldiv_start && MD_EN) ||
                ((state == HZ_BUSY) && (cnt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A pending memory wait freezes the whole pipeline, so the mul/div
    // sequencer must not advance either.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!mw) begin
            case (state)
                HZ_RUN: begin
                    if (muldiv_start && MD_EN) begin
                        state_next = HZ_BUSY;
                        cnt_next   = CNT_LOAD;
                    end
                end
                HZ_BUSY: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - 1'b1;
                    end else begin
                        state_next = HZ_RUN;
                    end
                end
                default: begin
                    state_next = HZ_RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_stall      = 1'b0;
        pc_bubble     = 1'b0;
        if_id_stall   = 1'b0;
        if_id_bubble  = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            if (mw) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (md) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_bubble = 1'b1;
            end else if (ex_redirect) begin
                // The ID instruction is squashed, so a load-use on it is moot.
                if_id_bubble = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (lu) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    hz_sat_counter #(
        .WIDTH (MW_W),
        .MAX   (TIMEOUT_V)
    ) u_memwait (
        .clk   (clk),
        .rst   (rst),
        .clr   (~mw),
        .inc   (mw),
        .count (memwait_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (mw && (memwait_cnt == TIMEOUT_V)) begin
            mem_err <= 1'b1;
        end
    end

    hz_sat_counter #(
        .WIDTH (32),
        .MAX   (32'hFFFF_FFFF)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (pc_stall),
        .count (stall_cycles)
    );

    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule
